// File: rtl/div_32x16_seq_if.sv
// Handshake and data bundle for div_32x16_seq: operand request side and result side.
interface div_32x16_seq_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] dividend;
    logic [15:0] divisor;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] quotient;
    logic [15:0] remainder;
    logic        ovf;
    logic        dbz;
    logic        chk_err;

    modport master (
        output in_valid, dividend, divisor, out_ready,
        input  in_ready, out_valid, quotient, remainder, ovf, dbz, chk_err
    );

    modport slave (
        input  in_valid, dividend, divisor, out_ready,
        output in_ready, out_valid, quotient, remainder, ovf, dbz, chk_err
    );
endinterface

// File: rtl/div_32x16_seq.sv
// Sequential 32/16 unsigned restoring divider, one quotient bit per cycle.
// Optional DIV_SELFCHECK_EN keeps the operands and flags results that fail q*d+r==dividend.
module div_32x16_seq (
    input  logic               clk,
    input  logic               rst_n,
    div_32x16_seq_if.slave     bus
);
    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t      state, state_next;
    logic [15:0] rem_r;
    logic [15:0] shf_r;
    logic [15:0] dvs_r;
    logic [3:0]  cnt;

    logic        accept;
    logic        start_ovf;
    logic [16:0] trial;
    logic [16:0] diff;
    logic        qbit;
    logic [15:0] rem_next;
    logic [15:0] shf_next;

    assign accept    = (state == IDLE) && bus.in_valid;
    assign start_ovf = (bus.divisor == 16'h0000) || (bus.dividend[31:16] >= bus.divisor);

    always_comb begin
        trial    = {rem_r, shf_r[15]};
        diff     = trial - {1'b0, dvs_r};
        qbit     = (trial >= {1'b0, dvs_r});
        rem_next = qbit ? diff[15:0] : trial[15:0];
        shf_next = {shf_r[14:0], qbit};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (accept) state_next = start_ovf ? DONE : RUN;
            RUN:  if (cnt == 4'd0) state_next = DONE;
            DONE: if (bus.out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign bus.in_ready = (state == IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bus.out_valid <= 1'b0;
            bus.quotient  <= '0;
            bus.remainder <= '0;
            bus.ovf       <= 1'b0;
            bus.dbz       <= 1'b0;
            rem_r         <= '0;
            shf_r         <= '0;
            dvs_r         <= '0;
            cnt           <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    dvs_r <= bus.divisor;
                    if (start_ovf) begin
                        bus.dbz       <= (bus.divisor == 16'h0000);
                        bus.ovf       <= 1'b1;
                        bus.quotient  <= '1;
                        bus.remainder <= '0;
                        bus.out_valid <= 1'b1;
                    end else begin
                        rem_r   <= bus.dividend[31:16];
                        shf_r   <= bus.dividend[15:0];
                        cnt     <= 4'd15;
                        bus.ovf <= 1'b0;
                        bus.dbz <= 1'b0;
                    end
                end
                RUN: begin
                    rem_r <= rem_next;
                    shf_r <= shf_next;
                    cnt   <= cnt - 4'd1;
                    if (cnt == 4'd0) begin
                        bus.quotient  <= shf_next;
                        bus.remainder <= rem_next;
                        bus.out_valid <= 1'b1;
                    end
                end
                DONE: if (bus.out_ready) bus.out_valid <= 1'b0;
                default: ;
            endcase
        end
    end

`ifdef DIV_SELFCHECK_EN
    logic [31:0] dvd_r;
    logic [31:0] recon;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      dvd_r <= '0;
        else if (accept) dvd_r <= bus.dividend;
    end

    assign recon       = ({16'h0000, bus.quotient} * {16'h0000, dvs_r}) + {16'h0000, bus.remainder};
    assign bus.chk_err = bus.out_valid && !bus.ovf && (recon != dvd_r);
`else
    assign bus.chk_err = 1'b0;
`endif
endmodule

// File: tb/tb_div_32x16_seq.sv
// Directed and random-invariant bench for div_32x16_seq with immediate-assertion checks.
module tb_div_32x16_seq;
    logic clk;
    logic rst_n;
    int   n_vec;
    int   n_err;

    div_32x16_seq_if bus ();

    div_32x16_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Drives one operand pair for one cycle; lat counts posedges after the accept edge
    // until out_valid is seen (0 for overflow, 16 for a full divide), capped at 40.
    task automatic run_op(input logic [31:0] dvd, input logic [15:0] dvs, output int lat);
        @(negedge clk);
        check("in_ready_before_accept", {31'b0, bus.in_ready}, 32'd1);
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        lat = 0;
        while (bus.out_valid !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic check_result(input string tag, input logic [15:0] q, input logic [15:0] r,
                                input logic o, input logic z);
        check({tag, "_quotient"},  {16'b0, bus.quotient},  {16'b0, q});
        check({tag, "_remainder"}, {16'b0, bus.remainder}, {16'b0, r});
        check({tag, "_ovf"},       {31'b0, bus.ovf},       {31'b0, o});
        check({tag, "_dbz"},       {31'b0, bus.dbz},       {31'b0, z});
        check({tag, "_chk_err"},   {31'b0, bus.chk_err},   32'd0);
    endtask

    task automatic release_result(input string tag);
        bus.out_ready = 1'b1;
        @(negedge clk);
        bus.out_ready = 1'b0;
        check({tag, "_valid_cleared"}, {31'b0, bus.out_valid}, 32'd0);
        check({tag, "_back_idle"},     {31'b0, bus.in_ready},  32'd1);
    endtask

    task automatic check_reset_values(input string tag);
        check({tag, "_out_valid"}, {31'b0, bus.out_valid}, 32'd0);
        check({tag, "_quotient"},  {16'b0, bus.quotient},  32'd0);
        check({tag, "_remainder"}, {16'b0, bus.remainder}, 32'd0);
        check({tag, "_ovf"},       {31'b0, bus.ovf},       32'd0);
        check({tag, "_dbz"},       {31'b0, bus.dbz},       32'd0);
        check({tag, "_chk_err"},   {31'b0, bus.chk_err},   32'd0);
        check({tag, "_in_ready"},  {31'b0, bus.in_ready},  32'd1);
    endtask

    initial begin
        int          lat;
        logic [15:0] d, q, r;
        logic [31:0] dvd;

        n_vec = 0;
        n_err = 0;
        rst_n = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.dividend  = '0;
        bus.divisor   = '0;
        repeat (2) @(negedge clk);
        check_reset_values("reset");
        rst_n = 1'b1;

        // Max product round trip
        run_op(32'hFFFE0001, 16'hFFFF, lat);
        check("maxprod_latency", lat, 32'd16);
        check_result("maxprod", 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        release_result("maxprod");

        run_op(32'h09A657FD, 16'h9876, lat);
        check("rem_latency", lat, 32'd16);
        check_result("rem", 16'h1034, 16'h0005, 1'b0, 1'b0);
        release_result("rem");

        // Largest dividend that still fits: high half one below divisor
        run_op(32'hFFFEFFFF, 16'hFFFF, lat);
        check_result("edge_fit", 16'hFFFF, 16'hFFFE, 1'b0, 1'b0);
        release_result("edge_fit");

        run_op(32'h00000064, 16'h0007, lat);
        check_result("small", 16'h000E, 16'h0002, 1'b0, 1'b0);
        release_result("small");

        run_op(32'h00000000, 16'h0003, lat);
        check_result("zero_dvd", 16'h0000, 16'h0000, 1'b0, 1'b0);
        release_result("zero_dvd");

        run_op(32'h00010000, 16'h0001, lat);
        check("ovf_latency", lat, 32'd0);
        check_result("ovf", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        release_result("ovf");

        // High half exactly equal to divisor overflows
        run_op(32'h00051234, 16'h0005, lat);
        check("ovf_eq_latency", lat, 32'd0);
        check_result("ovf_eq", 16'hFFFF, 16'h0000, 1'b1, 1'b0);
        release_result("ovf_eq");

        run_op(32'h12345678, 16'h0000, lat);
        check("dbz_latency", lat, 32'd0);
        check_result("dbz", 16'hFFFF, 16'h0000, 1'b1, 1'b1);
        release_result("dbz");

        // Backpressure: result held while new operands are offered and ignored
        run_op(32'h0000_0BB8, 16'h0064, lat);
        check_result("bp_first", 16'h001E, 16'h0000, 1'b0, 1'b0);
        for (int i = 0; i < 5; i++) begin
            bus.in_valid = (i % 2 == 0);
            bus.dividend = 32'h0001_0000 + i;
            bus.divisor  = 16'h0002;
            @(negedge clk);
            check("bp_out_valid", {31'b0, bus.out_valid}, 32'd1);
            check("bp_in_ready",  {31'b0, bus.in_ready},  32'd0);
            check("bp_quotient",  {16'b0, bus.quotient},  32'h001E);
            check("bp_remainder", {16'b0, bus.remainder}, 32'h0000);
        end
        bus.in_valid = 1'b0;
        release_result("bp");
        run_op(32'h0000_0011, 16'h0004, lat);
        check_result("bp_next", 16'h0004, 16'h0001, 1'b0, 1'b0);
        release_result("bp_next");

        // Reset in the middle of a RUN
        @(negedge clk);
        bus.dividend = 32'h0000_1234;
        bus.divisor  = 16'h0011;
        bus.in_valid = 1'b1;
        @(negedge clk);
        bus.in_valid = 1'b0;
        repeat (7) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check_reset_values("midrun_reset");
        @(negedge clk);
        check_reset_values("midrun_reset_held");
        rst_n = 1'b1;
        run_op(32'hFFFE0001, 16'hFFFF, lat);
        check("post_reset_latency", lat, 32'd16);
        check_result("post_reset", 16'hFFFF, 16'h0000, 1'b0, 1'b0);
        release_result("post_reset");

        // Random non-overflow pairs built from a chosen quotient and remainder
        for (int i = 0; i < 200; i++) begin
            d   = 16'($urandom_range(1, 65535));
            q   = 16'($urandom_range(0, 65535));
            r   = 16'($urandom_range(0, int'(d) - 1));
            dvd = {16'h0000, q} * {16'h0000, d} + {16'h0000, r};
            run_op(dvd, d, lat);
            check("rand_latency", lat, 32'd16);
            check_result("rand", q, r, 1'b0, 1'b0);
            release_result("rand");
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule

// File: doc/div_32x16_seq.md
# div_32x16_seq

Sequential restoring divider: the inverse of the 16x16 Dadda multipliers. It takes a 32-bit dividend (typically a product) and a 16-bit divisor and returns a 16-bit quotient and a 16-bit remainder. It resolves one quotient bit per cycle, with valid/ready handshakes on both sides. It sits next to the multipliers so that product round-trips can be checked in-system.

## Interface
Parameters: none; widths are fixed at 32/16.

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous reset, active-low
- in_valid  in  1  dividend/divisor valid
- in_ready  out  1  block can accept; high only in IDLE
- dividend  in  32  numerator
- divisor  in  16  denominator
- out_valid  out  1  result valid; held until accepted
- out_ready  in  1  consumer accepts result
- quotient  out  16  quotient
- remainder  out  16  remainder
- ovf  out  1  quotient does not fit in 16 bits (includes divide-by-zero)
- dbz  out  1  divisor was zero
- chk_err  out  1  self-check mismatch; see Configuration

## Operation
- States: IDLE, RUN, DONE. Reset state is IDLE.
- Reset values: out_valid=0, quotient=0, remainder=0, ovf=0, dbz=0, chk_err=0. in_ready=1 because it is decoded from IDLE.
- IDLE, on in_valid && in_ready:
  - If divisor==0: dbz=1, ovf=1, quotient=16'hFFFF, remainder=16'h0000, go to DONE.
  - Else if dividend[31:16] >= divisor: ovf=1, dbz=0, quotient=16'hFFFF, remainder=16'h0000, go to DONE.
  - Otherwise: load partial remainder R=dividend[31:16] and shift register S=dividend[15:0]; set counter=15, ovf=0, dbz=0; go to RUN.
- RUN, each cycle:
  - T = {R, S[15]} (17 bits).
  - If T >= {1'b0, divisor}: R = T - divisor (low 16 bits), and the new quotient bit is 1. Else R = T[15:0], and the bit is 0.
  - S shifts left with the quotient bit inserted at the LSB.
  - When counter==0: quotient=S (final), remainder=R, go to DONE. Otherwise decrement counter.
- DONE: out_valid=1. quotient, remainder, ovf and dbz are held stable. On out_ready, clear out_valid and go to IDLE at that edge.
- New operands are never accepted in RUN or DONE (in_ready=0). in_valid in those states is ignored and not queued.
- Arithmetic is unsigned only. Invariant for non-overflow results: quotient*divisor + remainder == dividend, with remainder < divisor.

## Timing
- Normal divide: the accept edge is E0. Iterations occur on E1..E16. out_valid becomes visible after E16, i.e. 16 cycles after acceptance.
- Overflow or divide-by-zero: out_valid becomes visible after E0 (1 cycle).
- Minimum throughput is one result per 18 cycles: accept, 16 RUN, DONE with out_ready=1. IDLE is revisited for at least one cycle between operations.
- All outputs except in_ready and chk_err are registered.
- rst_n assertion at any point, including mid-RUN or in DONE, immediately aborts the operation and forces the reset values. The first accept is possible on the first rising edge after rst_n deasserts.

## Configuration
- DIV_SELFCHECK_EN defined:
  - The original dividend and divisor are kept in registers.
  - chk_err = out_valid && !ovf && (quotient*divisor + remainder != dividend), combinational, 32-bit compare.
- Undefined: the operand copies are not built, and chk_err is tied to 0.
- All other behaviour is identical in both builds.

## Test plan
- Max-product round-trip: dividend=32'hFFFE0001, divisor=16'hFFFF -> out_valid 16 cycles after accept, quotient=16'hFFFF, remainder=16'h0000, ovf=0, dbz=0.
- Non-zero remainder: dividend=32'h09A657FD, divisor=16'h9876 -> quotient=16'h1034, remainder=16'h0005.
- Overflow: dividend=32'h00010000, divisor=16'h0001 -> ovf=1, dbz=0, quotient=16'hFFFF, remainder=0, out_valid 1 cycle after accept. Divisor=0 gives dbz=1 and ovf=1.
- Backpressure: hold out_ready=0 for 5 cycles in DONE while toggling in_valid with new operands -> outputs stable, in_ready=0, the new operands are not taken. Raise out_ready -> IDLE next cycle, then accept.
- Reset mid-operation: pull rst_n low at the 8th RUN cycle -> all outputs at reset values, in_ready=1. After release, 32'hFFFE0001/16'hFFFF completes correctly.
- Self-check build: 200 random non-overflow operand pairs with DIV_SELFCHECK_EN defined -> chk_err=0 throughout. Each result matches the invariant in the bench model.
